// File: rtl/tiny_wb_dma_spi_rx.sv
// -----------------------------------------------------------------------------
// tiny_wb_dma_spi_rx
//
// Receive-side DMA SPI master. Clocks size_i bytes in from an SPI slave
// (mode 0, MSB first), packs them little-endian into 32-bit words and writes
// each word to memory through a single-entry Wishbone master write buffer.
//
// Build option:
//   DMA_SPI_RX_DBUF_EN  defined   : separate shift register and write buffer,
//                                   shifting of the next word overlaps the
//                                   bus write of the previous one.
//                       undefined : one shared register; SCK pauses after
//                                   every word until its write is acked.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   wbm_spi_cyc_o/stb_o     bus request (cyc == stb)
//   wbm_spi_we_o            always 1 (write-only master)
//   wbm_spi_adr_o/dat_o     write address / data
//   wbm_spi_sel_o           byte enables (only received bytes set)
//   wbm_spi_ack_i           bus acknowledge
//   start_i                 start pulse, sampled in IDLE only
//   presc_i                 SCK half period = 8*presc_i+1 cycles
//   spi_adr_i, spi_inc_i    destination base, post-increment enable
//   size_i                  transfer length in bytes
//   rdy_o                   high while idle
//   spi_sck_o, spi_sdi_i    SPI clock (CPOL=0) and data from slave
// -----------------------------------------------------------------------------
module tiny_wb_dma_spi_rx #(
  parameter int MAX_SPI_LENGTH = 1024,
  localparam int SW = $clog2(MAX_SPI_LENGTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          wbm_spi_cyc_o,
  output logic          wbm_spi_stb_o,
  output logic          wbm_spi_we_o,
  output logic [31:0]   wbm_spi_adr_o,
  output logic [31:0]   wbm_spi_dat_o,
  output logic [3:0]    wbm_spi_sel_o,
  input  logic          wbm_spi_ack_i,
  input  logic          start_i,
  input  logic [3:0]    presc_i,
  input  logic [31:0]   spi_adr_i,
  input  logic          spi_inc_i,
  input  logic [SW-1:0] size_i,
  output logic          rdy_o,
  output logic          spi_sck_o,
  input  logic          spi_sdi_i
);

  typedef enum logic [1:0] {IDLE, SHIFT, STALL, FLUSH} state_t;

  state_t        state_q;
  logic [6:0]    cnt_q;      // prescaler down-counter
  logic          sck_q;
  logic          rdy_q;
  logic          stb_q;      // write buffer occupied
  logic [SW+2:0] bits_q;     // bits received so far in this transfer
  logic [SW-1:0] widx_q;     // index of the next word handed to the bus
  logic [31:0]   adr_q;
  logic [31:0]   dat_q;
  logic [3:0]    sel_q;

`ifdef DMA_SPI_RX_DBUF_EN
  logic [31:0]   sh_q;       // word being shifted in
  logic [3:0]    sh_sel_q;   // byte enables of a completed word awaiting the buffer
  logic          pend_q;     // sh_q holds a completed word not yet in the buffer
`endif

  logic          tick;
  logic [6:0]    reload;
  logic [SW+2:0] total_bits;
  logic [4:0]    pos;
  logic          last_bit;
  logic          word_done;
  logic [31:0]   cur_word;
  logic [31:0]   word_nxt;
  logic [3:0]    sel_nxt;
  logic [31:0]   word_adr;

  assign tick       = (cnt_q == 7'd0);
  assign reload     = {presc_i, 3'b000};
  assign total_bits = {size_i, 3'b000};
  assign pos        = bits_q[4:0];
  assign last_bit   = ((bits_q + (SW+3)'(1)) == total_bits);
  assign word_done  = (pos == 5'd31) || last_bit;
  assign word_adr   = spi_inc_i ? (spi_adr_i + 32'({widx_q, 2'b00})) : spi_adr_i;

`ifdef DMA_SPI_RX_DBUF_EN
  assign cur_word = sh_q;
`else
  assign cur_word = dat_q;
`endif

  // Bit k of the transfer (k = pos within the word) lands in byte pos[4:3] at
  // bit 7-pos[2:0]: MSB-first within a byte, bytes little-endian in the word.
  // The first bit of a word starts from zero so unreceived bytes read as 0.
  // NOTE: every combinational output gets a default before any conditional
  // update, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    word_nxt = (pos == 5'd0) ? 32'd0 : cur_word;
    word_nxt[pos ^ 5'd7] = spi_sdi_i;
    sel_nxt = {pos[4:3] == 2'd3, pos[4:3] >= 2'd2, pos[4:3] >= 2'd1, 1'b1};
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 7'd0;
      sck_q    <= 1'b0;
      rdy_q    <= 1'b1;
      stb_q    <= 1'b0;
      bits_q   <= '0;
      widx_q   <= '0;
      adr_q    <= 32'd0;
      dat_q    <= 32'd0;
      sel_q    <= 4'd0;
`ifdef DMA_SPI_RX_DBUF_EN
      sh_q     <= 32'd0;
      sh_sel_q <= 4'd0;
      pend_q   <= 1'b0;
`endif
    end else begin
      // Buffer release on ack. Every reload below is gated on stb_q being
      // already low, so a release and a reload never meet in one cycle and a
      // bus-idle cycle always separates consecutive writes.
      if (stb_q && wbm_spi_ack_i) stb_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start_i) begin
            rdy_q   <= 1'b0;
            bits_q  <= '0;
            widx_q  <= '0;
            cnt_q   <= reload;
            state_q <= (size_i != '0) ? SHIFT : FLUSH;
          end
        end

        SHIFT: begin
          if (!tick) begin
            cnt_q <= cnt_q - 7'd1;
          end else begin
            cnt_q <= reload;
            sck_q <= ~sck_q;
            if (!sck_q) begin
              // Rising edge: sample SDI into the current word.
              bits_q <= bits_q + (SW+3)'(1);
`ifdef DMA_SPI_RX_DBUF_EN
              sh_q <= word_nxt;
              if (word_done) begin
                if (!stb_q) begin
                  dat_q  <= word_nxt;
                  sel_q  <= sel_nxt;
                  adr_q  <= word_adr;
                  stb_q  <= 1'b1;
                  widx_q <= widx_q + SW'(1);
                end else begin
                  sh_sel_q <= sel_nxt;
                  pend_q   <= 1'b1;
                  state_q  <= STALL;
                end
              end
`else
              dat_q <= word_nxt;
              if (word_done) begin
                sel_q  <= sel_nxt;
                adr_q  <= word_adr;
                stb_q  <= 1'b1;
                widx_q <= widx_q + SW'(1);
                // The shared register must not shift while its write is
                // outstanding; the final word simply finishes its SCK cycle.
                if (!last_bit) state_q <= STALL;
              end
`endif
            end else if (bits_q == total_bits) begin
              // Falling edge after the last bit: SCK is now low for good.
              state_q <= FLUSH;
            end
          end
        end

        STALL: begin
          // Complete the falling edge of the current SCK cycle, then freeze.
          if (sck_q) begin
            if (tick) begin
              sck_q <= 1'b0;
              cnt_q <= reload;
            end else begin
              cnt_q <= cnt_q - 7'd1;
            end
          end
`ifdef DMA_SPI_RX_DBUF_EN
          if (pend_q && !stb_q) begin
            dat_q  <= sh_q;
            sel_q  <= sh_sel_q;
            adr_q  <= word_adr;
            stb_q  <= 1'b1;
            widx_q <= widx_q + SW'(1);
            pend_q <= 1'b0;
          end
          if (!sck_q && (!pend_q || !stb_q)) begin
`else
          if (!sck_q && !stb_q) begin
`endif
            cnt_q   <= reload;
            state_q <= (bits_q == total_bits) ? FLUSH : SHIFT;
          end
        end

        FLUSH: begin
          if (!stb_q || wbm_spi_ack_i) begin
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign wbm_spi_cyc_o = stb_q;
  assign wbm_spi_stb_o = stb_q;
  assign wbm_spi_we_o  = 1'b1;
  assign wbm_spi_adr_o = adr_q;
  assign wbm_spi_dat_o = dat_q;
  assign wbm_spi_sel_o = sel_q;
  assign rdy_o         = rdy_q;
  assign spi_sck_o     = sck_q;

endmodule

// File: tb/tb_tiny_wb_dma_spi_rx.sv
// -----------------------------------------------------------------------------
// Testbench for tiny_wb_dma_spi_rx. A behavioural model turns the byte stream
// into the expected list of Wishbone writes; a negedge monitor acts as SPI
// slave and Wishbone responder and compares every bus cycle and SCK phase.
// -----------------------------------------------------------------------------
module tb_tiny_wb_dma_spi_rx;
  localparam int SW = $clog2(1024 + 1);

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cyc, stb, we, ack;
  logic [31:0]   adr, dat;
  logic [3:0]    sel;
  logic          start;
  logic [3:0]    presc;
  logic [31:0]   spi_adr;
  logic          inc;
  logic [SW-1:0] size;
  logic          rdy, sck, sdi;

  always #5 clk = ~clk;

  tiny_wb_dma_spi_rx #(.MAX_SPI_LENGTH(1024)) dut (
    .clk_i(clk), .rst_i(rst),
    .wbm_spi_cyc_o(cyc), .wbm_spi_stb_o(stb), .wbm_spi_we_o(we),
    .wbm_spi_adr_o(adr), .wbm_spi_dat_o(dat), .wbm_spi_sel_o(sel),
    .wbm_spi_ack_i(ack),
    .start_i(start), .presc_i(presc), .spi_adr_i(spi_adr), .spi_inc_i(inc),
    .size_i(size), .rdy_o(rdy), .spi_sck_o(sck), .spi_sdi_i(sdi)
  );

  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0] tx_bytes [0:63];
  wr_t  exp_q[$];
  wr_t  got_q[$];

  int   rise_cnt = 0;
  int   ack_delay = 0;
  int   ack_wait = 0;
  int   cur_h = 1;
  int   phase_len = 0;
  bit   first_pend = 0;
  bit   chk_sck = 1;
  bit   late_ack = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Expected writes: consecutive groups of four bytes, first byte lowest.
  function automatic void build_model(input int n, input bit inc_v, input logic [31:0] base);
    exp_q.delete();
    for (int w = 0; w * 4 < n; w++) begin
      wr_t e;
      e.dat = 32'd0;
      e.sel = 4'd0;
      for (int b = 0; b < 4; b++) begin
        if (w * 4 + b < n) begin
          e.dat[8*b +: 8] = tx_bytes[w * 4 + b];
          e.sel[b] = 1'b1;
        end
      end
      e.adr = inc_v ? base + 32'(4 * w) : base;
      exp_q.push_back(e);
    end
  endfunction

  // Monitor: SPI slave, bus responder, bus checker, SCK timing checker.
  initial begin
    logic sck_prev = 1'b0, stb_prev = 1'b0, rdy_prev = 1'b1, ack_prev = 1'b0;
    logic resp;
    wr_t  cap;
    wr_t  w;
    wr_t  e;
    forever begin
      @(negedge clk);
      if (stb) begin
        check("cyc_eq_stb", cyc, stb);
        check("we_const", we, 1'b1);
        if (!stb_prev) begin
          w.adr = adr; w.dat = dat; w.sel = sel;
          got_q.push_back(w);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got adr %0h dat %0h, required no write", adr, dat);
          end else begin
            e = exp_q.pop_front();
            check("wr_adr", adr, e.adr);
            check("wr_dat", dat, e.dat);
            check("wr_sel", sel, e.sel);
          end
          cap = w;
          ack_wait = 0;
        end else begin
          check("adr_stable", adr, cap.adr);
          check("dat_stable", dat, cap.dat);
          check("sel_stable", sel, cap.sel);
          if (ack_prev) check("bus_release", stb, 1'b0);
        end
      end
      resp = 1'b0;
      if (stb) begin
        if (ack_wait >= ack_delay) resp = 1'b1;
        else ack_wait++;
      end
      ack = resp | late_ack;

      if (rdy_prev && !rdy) begin
        phase_len = 1;
        first_pend = 1;
      end else if (sck != sck_prev) begin
        if (chk_sck) begin
          if (sck && first_pend) check("first_rise_delay", phase_len, cur_h);
          if (!sck) check("sck_high_len", phase_len, cur_h);
        end
        if (sck) first_pend = 0;
        phase_len = 1;
      end else begin
        phase_len++;
      end

      if (sck && !sck_prev) begin
        rise_cnt++;
`ifndef DMA_SPI_RX_DBUF_EN
        check("sck_edge_during_write", stb_prev, 1'b0);
`endif
      end
      sdi = (rise_cnt < 512) ? tx_bytes[rise_cnt / 8][7 - (rise_cnt % 8)] : 1'b0;

      sck_prev = sck;
      stb_prev = stb;
      rdy_prev = rdy;
      ack_prev = ack;
    end
  end

  task automatic start_xfer(input int n, input bit inc_v, input logic [31:0] base,
                            input logic [3:0] p, input int dly);
    build_model(n, inc_v, base);
    got_q.delete();
    ack_delay = dly;
    cur_h = 8 * p + 1;
    @(posedge clk); #1;
    rise_cnt = 0;
    size = n[SW-1:0];
    presc = p;
    spi_adr = base;
    inc = inc_v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("rdy_drop", rdy, 1'b0);
  endtask

  task automatic finish_xfer(input int n, output int low_cycles);
    int budget = 20000;
    low_cycles = 0;
    while (!rdy && budget > 0) begin
      @(posedge clk); #1;
      budget--;
      low_cycles++;
    end
    check("xfer_done", rdy, 1'b1);
    check("rise_count", rise_cnt, 8 * n);
    check("writes_pending", exp_q.size(), 0);
    check("sck_idle", sck, 1'b0);
    check("bus_idle_at_rdy", stb, 1'b0);
  endtask

  task automatic run_xfer(input int n, input bit inc_v, input logic [31:0] base,
                          input logic [3:0] p, input int dly);
    int lc;
    start_xfer(n, inc_v, base, p, dly);
    finish_xfer(n, lc);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset_and_check(input string tag);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check({tag, "_cyc"}, cyc, 1'b0);
    check({tag, "_stb"}, stb, 1'b0);
    check({tag, "_sck"}, sck, 1'b0);
    check({tag, "_rdy"}, rdy, 1'b1);
    check({tag, "_adr"}, adr, 32'd0);
    check({tag, "_dat"}, dat, 32'd0);
    check({tag, "_sel"}, sel, 4'd0);
    exp_q.delete();
  endtask

  initial begin
    int lc;
    int budget;
    rst = 1'b1; start = 1'b0; presc = 4'd0; spi_adr = 32'd0; inc = 1'b0;
    size = '0; sdi = 1'b0; ack = 1'b0;
    for (int i = 0; i < 64; i++) tx_bytes[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", rdy, 1'b1);
    check("rst_sck", sck, 1'b0);
    check("rst_cyc", cyc, 1'b0);
    check("rst_stb", stb, 1'b0);
    check("rst_we", we, 1'b1);
    check("rst_adr", adr, 32'd0);
    check("rst_dat", dat, 32'd0);
    check("rst_sel", sel, 4'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Single full word, fastest SCK, immediate ack.
    tx_bytes[0] = 8'hA5; tx_bytes[1] = 8'h3C; tx_bytes[2] = 8'h0F; tx_bytes[3] = 8'hF0;
    run_xfer(4, 1'b1, 32'h100, 4'd0, 0);
    check("t1_nwr", got_q.size(), 1);
    check("t1_adr", got_q[0].adr, 32'h100);
    check("t1_dat", got_q[0].dat, 32'hF00F3CA5);
    check("t1_sel", got_q[0].sel, 4'hF);

    // Full word plus a 2-byte tail.
    for (int i = 0; i < 8; i++) tx_bytes[i] = 8'(i + 1);
    run_xfer(6, 1'b1, 32'h100, 4'd0, 0);
    check("t2_nwr", got_q.size(), 2);
    check("t2_adr0", got_q[0].adr, 32'h100);
    check("t2_dat0", got_q[0].dat, 32'h04030201);
    check("t2_adr1", got_q[1].adr, 32'h104);
    check("t2_dat1", got_q[1].dat, 32'h00000605);
    check("t2_sel1", got_q[1].sel, 4'h3);

    // Fixed address.
    run_xfer(8, 1'b0, 32'h100, 4'd0, 0);
    check("t3_nwr", got_q.size(), 2);
    check("t3_adr1", got_q[1].adr, 32'h100);
    check("t3_dat0", got_q[0].dat, 32'h04030201);
    check("t3_dat1", got_q[1].dat, 32'h08070605);

    // Slow acks force stalls.
    for (int i = 0; i < 12; i++) tx_bytes[i] = 8'(8'hC3 + 8'(i * 29));
    run_xfer(12, 1'b1, 32'h400, 4'd0, 80);
    check("t4_nwr", got_q.size(), 3);

    // Zero-length transfer.
    start_xfer(0, 1'b1, 32'h100, 4'd0, 0);
    finish_xfer(0, lc);
    check("t5_rdy_low_cycles", lc, 1);
    check("t5_nwr", got_q.size(), 0);
    repeat (2) @(posedge clk);

    // Partial word, mid prescaler.
    tx_bytes[0] = 8'hDE; tx_bytes[1] = 8'hAD; tx_bytes[2] = 8'hBE;
    run_xfer(3, 1'b1, 32'h2000, 4'd3, 2);
    check("t6_dat", got_q[0].dat, 32'h00BEADDE);
    check("t6_sel", got_q[0].sel, 4'h7);
    check("t6_adr", got_q[0].adr, 32'h2000);

    // Single byte, slowest SCK (period 242).
    tx_bytes[0] = 8'h81;
    run_xfer(1, 1'b1, 32'h40, 4'd15, 0);
    check("t7_dat", got_q[0].dat, 32'h00000081);
    check("t7_sel", got_q[0].sel, 4'h1);

    // Moderate prescaler with acks that arrive while the next word shifts.
    for (int i = 0; i < 9; i++) tx_bytes[i] = 8'(8'h5A ^ 8'(i * 17));
    run_xfer(9, 1'b1, 32'h300, 4'd1, 20);
    check("t8_nwr", got_q.size(), 3);

    // Reset mid word.
    chk_sck = 0;
    for (int i = 0; i < 8; i++) tx_bytes[i] = 8'(i + 1);
    start_xfer(8, 1'b1, 32'h200, 4'd0, 0);
    budget = 500;
    while (rise_cnt < 13 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("reach_bit13", rise_cnt >= 13, 1'b1);
    pulse_reset_and_check("rst_mid");

    // Reset during a pending write, then a late ack.
    start_xfer(4, 1'b1, 32'h200, 4'd0, 100000);
    budget = 500;
    while (!stb && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("write_pending", stb, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    pulse_reset_and_check("rst_wr");
    late_ack = 1;
    repeat (3) begin
      @(posedge clk); #1;
      check("late_ack_ignored", cyc, 1'b0);
    end
    late_ack = 0;
    check("late_ack_rdy", rdy, 1'b1);
    ack_delay = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_sck = 1;

    // Clean transfer after reset.
    run_xfer(6, 1'b1, 32'h100, 4'd0, 0);
    check("t9_nwr", got_q.size(), 2);
    check("t9_dat0", got_q[0].dat, 32'h04030201);
    check("t9_dat1", got_q[1].dat, 32'h00000605);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
